// File: rtl/xilinx_rst_seq_pkg.sv
// rtl/xilinx_rst_seq_pkg.sv - shared state encoding and helpers for the reset sequencer
package xilinx_rst_seq_pkg;

    // Encoding is visible on state_o and relied upon by VIO/debug logic.
    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_DRAM_RST   = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_HOLD       = 3'd3,
        ST_RUN        = 3'd4,
        ST_ERROR      = 3'd5
    } rst_state_e;

    localparam int unsigned SyncStages = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// rtl/rst_debounce.sv - saturating stable-high debounce for an already synchronized request
module rst_debounce #(
    parameter int unsigned Cycles = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic out_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Cycles);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Any low cycle restarts the count; the count parks at CntMax while held.
    always_comb begin
        cnt_d = '0;
        if (in_i) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_o = (cnt_q == CntMax);

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - common-cells multi-flop synchronizer for a single asynchronous bit
module sync #(
    parameter int unsigned STAGES     = 2,
    parameter bit          ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= {STAGES{ResetValue}};
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/xilinx_rst_seq.sv
// rtl/xilinx_rst_seq.sv - board reset sequencer: PLL lock, DRAM reset/calibration, SoC release
module xilinx_rst_seq
    import xilinx_rst_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles = 1000,
    parameter int unsigned HoldCycles     = 16,
    parameter int unsigned CalibTimeout   = 2**20,
    parameter bit          UseDram        = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       btn_rst_i,
    input  logic       vio_rst_i,
    input  logic       calib_done_i,
    input  logic [1:0] boot_mode_i,
    output logic       soc_rst_no,
    output logic       dram_rst_o,
    output logic [1:0] boot_mode_o,
    output logic [2:0] state_o,
    output logic       err_o
);

    localparam int unsigned NumSync = 6;
    localparam int unsigned CntW = $clog2(max_u(HoldCycles, CalibTimeout)) + 1;
    localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeout - 1);

    logic [NumSync-1:0] async_in, synced;
    logic               locked, btn_sync, vio_sync, calib_done;
    logic [1:0]         boot_sync;
    logic               btn_deb, rst_req;

    rst_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            soc_rst_n_q, soc_rst_n_d;
    logic            dram_rst_q, dram_rst_d;
    logic [1:0]      boot_mode_q, boot_mode_d;
    logic            err_q, err_d;

    assign async_in = {boot_mode_i, calib_done_i, vio_rst_i, btn_rst_i, pll_locked_i};

    for (genvar i = 0; i < NumSync; i++) begin : g_sync
        sync #(
            .STAGES    (SyncStages),
            .ResetValue(1'b0)
        ) u_sync (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .serial_i(async_in[i]),
            .serial_o(synced[i])
        );
    end

    assign locked     = synced[0];
    assign btn_sync   = synced[1];
    assign vio_sync   = synced[2];
    assign calib_done = synced[3];
    assign boot_sync  = synced[5:4];

    rst_debounce #(
        .Cycles(DebounceCycles)
    ) u_btn_debounce (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .in_i  (btn_sync),
        .out_o (btn_deb)
    );

    assign rst_req = btn_deb | vio_sync;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK:  if (locked && !rst_req) state_d = UseDram ? ST_DRAM_RST : ST_HOLD;
            ST_DRAM_RST:   if (cnt_q == HoldLast) state_d = ST_WAIT_CALIB;
            ST_WAIT_CALIB: begin
                if (calib_done) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == CalibLast) begin
                    state_d = ST_ERROR;
                end
            end
            ST_HOLD:       if (cnt_q == HoldLast) state_d = ST_RUN;
            ST_RUN:        state_d = ST_RUN;
            ST_ERROR:      if (rst_req) state_d = ST_WAIT_LOCK;
            default:       state_d = ST_WAIT_LOCK;
        endcase
        // ERROR latches through lock loss so the failure stays visible until reset is requested.
        if (state_q != ST_ERROR && (!locked || rst_req)) begin
            state_d = ST_WAIT_LOCK;
        end

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {ST_DRAM_RST, ST_WAIT_CALIB, ST_HOLD}) begin
            cnt_d = cnt_q + CntW'(1);
        end

        soc_rst_n_d = (state_d == ST_RUN);
        dram_rst_d  = (state_d inside {ST_WAIT_LOCK, ST_DRAM_RST, ST_ERROR});
        boot_mode_d = (state_q == ST_HOLD && state_d == ST_RUN) ? boot_sync : boot_mode_q;

        err_d = err_q;
        if (state_d == ST_ERROR && state_q != ST_ERROR) begin
            err_d = 1'b1;
        end else if (state_q == ST_ERROR && state_d == ST_WAIT_LOCK) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            soc_rst_n_q <= 1'b0;
            dram_rst_q  <= 1'b1;
            boot_mode_q <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            soc_rst_n_q <= soc_rst_n_d;
            dram_rst_q  <= dram_rst_d;
            boot_mode_q <= boot_mode_d;
            err_q       <= err_d;
        end
    end

    assign soc_rst_no  = soc_rst_n_q;
    assign dram_rst_o  = dram_rst_q;
    assign boot_mode_o = boot_mode_q;
    assign state_o     = state_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_xilinx_rst_seq.sv
// tb/tb_xilinx_rst_seq.sv - scoreboard bench for xilinx_rst_seq with and without DRAM
module tb_xilinx_rst_seq;

    localparam int S_SOC = 0, S_DRAM = 1, S_BOOT = 2, S_STATE = 3, S_ERR = 4, ND = 5;

    typedef struct {
        string       tag;
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    bit   clk_en = 1'b1;
    logic rst_n, lock, btn, vio, calib, lock_nd;
    logic [1:0] boot, boot_nd;
    logic       soc_n, dram, err, soc_n_nd, dram_nd, err_nd;
    logic [1:0] boot_o, boot_o_nd;
    logic [2:0] state, state_nd;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;
    exp_t sb[$];

    always #5 if (clk_en) clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    xilinx_rst_seq #(
        .DebounceCycles(8), .HoldCycles(4), .CalibTimeout(64), .UseDram(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(lock), .btn_rst_i(btn), .vio_rst_i(vio),
        .calib_done_i(calib), .boot_mode_i(boot), .soc_rst_no(soc_n), .dram_rst_o(dram),
        .boot_mode_o(boot_o), .state_o(state), .err_o(err)
    );

    xilinx_rst_seq #(
        .DebounceCycles(8), .HoldCycles(4), .CalibTimeout(64), .UseDram(1'b0)
    ) dut_nd (
        .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(lock_nd), .btn_rst_i(btn), .vio_rst_i(vio),
        .calib_done_i(1'b0), .boot_mode_i(boot_nd), .soc_rst_no(soc_n_nd), .dram_rst_o(dram_nd),
        .boot_mode_o(boot_o_nd), .state_o(state_nd), .err_o(err_nd)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_SOC:        return {31'd0, soc_n};
            S_DRAM:       return {31'd0, dram};
            S_BOOT:       return {30'd0, boot_o};
            S_STATE:      return {29'd0, state};
            S_ERR:        return {31'd0, err};
            ND + S_SOC:   return {31'd0, soc_n_nd};
            ND + S_DRAM:  return {31'd0, dram_nd};
            ND + S_BOOT:  return {30'd0, boot_o_nd};
            ND + S_STATE: return {29'd0, state_nd};
            default:      return {31'd0, err_nd};
        endcase
    endfunction

    function automatic void push_at(input string tag, input int c, input int sig, input int val);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endfunction

    function automatic void push(input string tag, input int lat, input int sig, input int val);
        push_at(tag, cyc + lat, sig, val);
    endfunction

    function automatic void expect_dut(input string tag, input int lat, input int st, input int soc,
                                       input int dr);
        push({tag, "_state"}, lat, S_STATE, st);
        push({tag, "_soc"}, lat, S_SOC, soc);
        push({tag, "_dram"}, lat, S_DRAM, dr);
    endfunction

    task automatic compare_due(input int c);
        exp_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].cyc == c) check(sb[i].tag, actual(sb[i].sig), sb[i].val);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    always @(negedge clk) compare_due(cyc);

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; lock = 1'b0; btn = 1'b0; vio = 1'b0; calib = 1'b0;
        boot = 2'b10; lock_nd = 1'b0; boot_nd = 2'b01;
        wait_cyc(3);
        expect_dut("rst", 0, 0, 0, 1);
        push("rst_err", 0, S_ERR, 0);
        push("rst_boot", 0, S_BOOT, 0);
        push("rst_nd_state", 0, ND + S_STATE, 0);
        push("rst_nd_dram", 0, ND + S_DRAM, 1);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(3);

        // No-DRAM variant: lock -> HOLD -> RUN after 2+1+4 cycles
        lock_nd = 1'b1;
        push("nd_wl_state", 2, ND + S_STATE, 0);
        push("nd_wl_dram", 2, ND + S_DRAM, 1);
        push("nd_hold_state", 3, ND + S_STATE, 3);
        push("nd_hold_dram", 3, ND + S_DRAM, 0);
        push("nd_hold_soc", 6, ND + S_SOC, 0);
        push("nd_run_state", 7, ND + S_STATE, 4);
        push("nd_run_soc", 7, ND + S_SOC, 1);
        push("nd_run_dram", 7, ND + S_DRAM, 0);
        push("nd_run_boot", 7, ND + S_BOOT, 1);
        wait_cyc(10);

        // Normal bring-up
        lock = 1'b1;
        expect_dut("lk_wait", 2, 0, 0, 1);
        expect_dut("lk_dram", 3, 1, 0, 1);
        expect_dut("lk_dram_end", 6, 1, 0, 1);
        expect_dut("lk_calib", 7, 2, 0, 0);
        wait_cyc(30);
        calib = 1'b1;
        expect_dut("cd_hold", 3, 3, 0, 0);
        expect_dut("cd_hold_end", 6, 3, 0, 0);
        push("cd_boot_pre", 6, S_BOOT, 0);
        expect_dut("cd_run", 7, 4, 1, 0);
        push("cd_boot", 7, S_BOOT, 2);
        wait_cyc(12);

        // Short button bounce is ignored
        btn = 1'b1;
        expect_dut("btn5_a", 11, 4, 1, 0);
        expect_dut("btn5_b", 13, 4, 1, 0);
        wait_cyc(5);
        btn = 1'b0;
        wait_cyc(15);

        // Long press resets the SoC 2+8+1 cycles after the press, then resequences
        btn = 1'b1;
        expect_dut("btn10_pre", 10, 4, 1, 0);
        expect_dut("btn10_rst", 11, 0, 0, 1);
        expect_dut("btn10_held", 13, 0, 0, 1);
        push("btn10_boot_hold", 15, S_BOOT, 2);
        expect_dut("btn10_dram", 14, 1, 0, 1);
        expect_dut("btn10_calib", 18, 2, 0, 0);
        expect_dut("btn10_hold", 19, 3, 0, 0);
        expect_dut("btn10_hold_end", 22, 3, 0, 0);
        expect_dut("btn10_run", 23, 4, 1, 0);
        wait_cyc(10);
        btn = 1'b0;
        wait_cyc(20);

        // Lock loss in RUN
        lock = 1'b0;
        expect_dut("ll_pre", 2, 4, 1, 0);
        expect_dut("ll_rst", 3, 0, 0, 1);
        wait_cyc(5);
        lock = 1'b1;
        expect_dut("ll_dram", 3, 1, 0, 1);
        expect_dut("ll_calib", 7, 2, 0, 0);
        expect_dut("ll_hold", 8, 3, 0, 0);
        expect_dut("ll_hold_end", 11, 3, 0, 0);
        expect_dut("ll_run", 12, 4, 1, 0);
        wait_cyc(15);

        // Calibration timeout: ERROR exactly 64 cycles after WAIT_CALIB entry
        calib = 1'b0;
        lock = 1'b0;
        expect_dut("to_wait", 3, 0, 0, 1);
        wait_cyc(6);
        lock = 1'b1;
        expect_dut("to_calib", 7, 2, 0, 0);
        expect_dut("to_last", 70, 2, 0, 0);
        push("to_err_pre", 70, S_ERR, 0);
        expect_dut("to_error", 71, 5, 0, 1);
        push("to_err", 71, S_ERR, 1);
        wait_cyc(74);
        lock = 1'b0;
        expect_dut("err_lockloss", 6, 5, 0, 1);
        push("err_lockloss_err", 6, S_ERR, 1);
        wait_cyc(8);

        // vio pulse leaves ERROR, clears err_o and restarts
        vio = 1'b1;
        lock = 1'b1;
        push("vio_err_pre", 2, S_ERR, 1);
        push("vio_state_pre", 2, S_STATE, 5);
        expect_dut("vio_exit", 3, 0, 0, 1);
        push("vio_err_clr", 3, S_ERR, 0);
        push("vio_held", 10, S_STATE, 0);
        expect_dut("vio_dram", 11, 1, 0, 1);
        wait_cyc(8);
        vio = 1'b0;
        wait_cyc(3);
        calib = 1'b1;
        expect_dut("vio_calib", 4, 2, 0, 0);
        expect_dut("vio_hold", 5, 3, 0, 0);
        expect_dut("vio_run", 9, 4, 1, 0);
        wait_cyc(12);

        // Asynchronous reset in WAIT_CALIB with the clock stopped
        calib = 1'b0;
        lock = 1'b0;
        wait_cyc(6);
        lock = 1'b1;
        push("ar_calib", 7, S_STATE, 2);
        wait_cyc(10);
        @(negedge clk);
        #1;
        clk_en = 1'b0;
        #20;
        push_at("ar_pre_state", -1, S_STATE, 2);
        compare_due(-1);
        rst_n = 1'b0;
        #1;
        push_at("ar_state", -1, S_STATE, 0);
        push_at("ar_soc", -1, S_SOC, 0);
        push_at("ar_dram", -1, S_DRAM, 1);
        push_at("ar_boot", -1, S_BOOT, 0);
        push_at("ar_err", -1, S_ERR, 0);
        push_at("ar_nd_state", -1, ND + S_STATE, 0);
        push_at("ar_nd_soc", -1, ND + S_SOC, 0);
        compare_due(-1);
        #10;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
        wait_cyc(1);
        push("ar_restart0", 0, S_STATE, 0);
        expect_dut("ar_restart1", 1, 0, 0, 1);
        expect_dut("ar_restart2", 2, 1, 0, 1);
        push("ar_nd_hold", 2, ND + S_STATE, 3);
        wait_cyc(10);

        check("sb_pending", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/xilinx_rst_seq.md
XILINX_RST_SEQ -- requirements
Module: xilinx_rst_seq

Interface
REQ-001 SHALL have parameter DebounceCycles, default 1000: cycles a reset request must be stably asserted before it is accepted.
REQ-002 SHALL have parameter HoldCycles, default 16: length of the DRAM reset pulse, and pre-release hold before SoC reset deassertion.
REQ-003 SHALL have parameter CalibTimeout, default 2**20: cycles allowed for DRAM calibration.
REQ-004 SHALL have parameter UseDram, default 1: 0 skips the DRAM_RST and WAIT_CALIB states.
REQ-005 SHALL have port clk_i, input, 1 bit: SoC clock, the single clock of the block.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset; one clock; asynchronous, active-low.
REQ-007 SHALL have port pll_locked_i, input, 1 bit: clock wizard locked, asynchronous.
REQ-008 SHALL have port btn_rst_i, input, 1 bit: board reset button, active-high, asynchronous, may bounce.
REQ-009 SHALL have port vio_rst_i, input, 1 bit: debug reset request, active-high, asynchronous.
REQ-010 SHALL have port calib_done_i, input, 1 bit: DRAM calibration complete, asynchronous.
REQ-011 SHALL have port boot_mode_i, input, 2 bits: quasi-static boot mode.
REQ-012 SHALL have port soc_rst_no, output, 1 bit: SoC reset, active-low.
REQ-013 SHALL have port dram_rst_o, output, 1 bit: DRAM controller reset, active-high.
REQ-014 SHALL have port boot_mode_o, output, 2 bits: boot mode latched at SoC release.
REQ-015 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-016 SHALL have port err_o, output, 1 bit: sticky calibration-timeout flag.

Function
REQ-017 SHALL pass pll_locked_i, btn_rst_i, vio_rst_i, calib_done_i and boot_mode_i through 2-flop synchronizers (2-cycle latency) before any use.
REQ-018 SHALL form rst_req = debounced(btn) OR synced vio.
REQ-019 SHALL set debounced(btn) only after synced btn has been high for DebounceCycles consecutive cycles; any low cycle clears the counter, and the counter saturates without wrapping.
REQ-020 SHALL implement states WAIT_LOCK=0, DRAM_RST=1, WAIT_CALIB=2, HOLD=3, RUN=4 and ERROR=5; reset state is WAIT_LOCK.
REQ-021 SHALL have WAIT_LOCK go to DRAM_RST when locked and no rst_req; if UseDram=0, it goes to HOLD.
REQ-022 SHALL hold DRAM_RST with dram_rst_o=1 for HoldCycles cycles, then go to WAIT_CALIB.
REQ-023 SHALL have WAIT_CALIB go to HOLD on synced calib_done; if the counter reaches CalibTimeout-1 first, it goes to ERROR; if both happen in the same cycle, calib_done wins.
REQ-024 SHALL have HOLD count HoldCycles cycles, then go to RUN.
REQ-025 SHALL have any state except ERROR go to WAIT_LOCK on loss of lock or on rst_req; this has priority over all other transitions.
REQ-026 SHALL have ERROR go to WAIT_LOCK only on rst_req and SHALL ignore lock loss there.
REQ-027 SHALL clear err_o on the ERROR-to-WAIT_LOCK transition and set it on entry to ERROR.
REQ-028 SHALL set dram_rst_o=1 in WAIT_LOCK, DRAM_RST and ERROR, and 0 elsewhere.
REQ-029 SHALL register all outputs, updated on the same edge as the state register.
REQ-030 SHALL drive soc_rst_no=1 iff state==RUN.
REQ-031 SHALL load boot_mode_o with the synced boot_mode on the HOLD-to-RUN edge and hold it otherwise.
REQ-032 SHALL share one counter for the DRAM_RST, WAIT_CALIB and HOLD states, cleared on every state change, with width $clog2(max(HoldCycles,CalibTimeout))+1.

Reset
REQ-033 SHALL, while rst_ni=0, force asynchronously: state=WAIT_LOCK, soc_rst_no=0, dram_rst_o=1, boot_mode_o=0, err_o=0, all counters=0, and all synchronizer flops=0.
REQ-034 SHALL, when rst_ni is asserted mid-sequence, abandon the sequence with no partial output pulse, and restart from WAIT_LOCK after rst_ni deasserts.

Structure
REQ-035 SHALL define the state enum and its 3-bit encoding in the shared package xilinx_rst_seq_pkg, for use by VIO and debug logic.
REQ-036 SHALL put the debounce counter in the sub-module rst_debounce; synchronizers SHALL use the existing common cells sync cell.

Verification (DebounceCycles=8, HoldCycles=4, CalibTimeout=64)
REQ-037 SHALL cover: lock rises at cycle 10 and calib_done rises at cycle 40 with boot_mode_i=2'b10 -> dram_rst_o low after 4 cycles of DRAM_RST; soc_rst_no rises 2+4+1 cycles after the calib_done edge; boot_mode_o=2'b10.
REQ-038 SHALL cover: calib_done held low -> err_o=1 and state_o=5 exactly 64 cycles after WAIT_CALIB entry; soc_rst_no stays 0; a subsequent 8-cycle vio pulse clears err_o and restarts the sequence.
REQ-039 SHALL cover: in RUN, a 5-cycle btn pulse -> no change; a 10-cycle btn pulse -> soc_rst_no falls 2+8+1 cycles after the press edge, followed by a full resequence.
REQ-040 SHALL cover: pll_locked_i drops in RUN -> soc_rst_no=0 and dram_rst_o=1 within 3 cycles; when lock returns, the normal sequence runs again.
REQ-041 SHALL cover: UseDram=0 with calib_done_i tied 0 -> RUN reached 2+1+4 cycles after lock, with dram_rst_o held 0 outside WAIT_LOCK.
REQ-042 SHALL cover: rst_ni pulsed low in WAIT_CALIB with the clock stopped -> outputs take their reset values immediately.
